// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and default widths for the CPU run controller.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  localparam int DEF_DATA_W    = 64;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_CNT_W     = 32;
  localparam int DEF_MAX_STEPS = 1000000;

endpackage

// File: rtl/run_out_fifo.sv
// Output word FIFO: registered head word, occupancy count and synchronous flush.
module run_out_fifo
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CW-1:0]     count_reg;
  logic [DATA_W-1:0] head_reg;
  logic              wr_en, rd_en;

  assign wr_en      = push & (count_reg != CW'(DEPTH));
  assign rd_en      = pop & (count_reg != '0);
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // The head register tracks mem[rd_ptr]; with two or more entries the next
  // word is already in memory, otherwise it comes straight from the push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_inc;
      if (wr_en && !rd_en) count_reg <= count_reg + CW'(1);
      else if (rd_en && !wr_en) count_reg <= count_reg - CW'(1);
      if (rd_en) begin
        if (count_reg > CW'(1)) head_reg <= mem[rd_ptr_inc];
        else if (wr_en)         head_reg <= push_data;
        else                    head_reg <= '0;
      end else if (wr_en && count_reg == '0) begin
        head_reg <= push_data;
      end
    end
  end

  assign head_valid = (count_reg != '0);
  assign head_data  = head_reg;
  assign count      = count_reg;

endmodule

// File: rtl/cpu_run_controller.sv
// Runs the CPU with a clock enable, buffers its output words and reports completion.
// Define CPU_RUN_CTRL_TIMEOUT_EN to end a run when the MAX_STEPS budget is used up.
module cpu_run_controller
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              cpu_rst,
  output logic              cpu_en,
  input  logic              cpu_halt,
  input  logic              cpu_valid,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  step_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  run_state_e       state_reg, state_next;
  logic [CW-1:0]    fifo_count;
  logic             fifo_push, fifo_pop, fifo_flush;
  logic             halt_step, timeout_step, start_ok, drain_empty;
  logic [CNT_W-1:0] step_count_reg;
  logic             timed_out_reg;

  assign fifo_push   = cpu_en & cpu_valid;
  assign fifo_pop    = out_valid & out_ready & (state_reg != IDLE);
  assign fifo_flush  = abort & (state_reg != IDLE);
  assign halt_step   = cpu_en & cpu_halt;
  assign start_ok    = start & ~abort & ((state_reg == IDLE) | (state_reg == DONE));
  // Empty once this cycle's pop has been taken into account.
  assign drain_empty = (fifo_count == '0) | ((fifo_count == CW'(1)) & fifo_pop);

`ifdef CPU_RUN_CTRL_TIMEOUT_EN
  assign timeout_step = cpu_en & ~cpu_halt & (step_count_reg == CNT_W'(MAX_STEPS - 1));
`else
  logic unused_max_steps;
  assign unused_max_steps = (MAX_STEPS != 0);
  assign timeout_step     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (halt_step || timeout_step) state_next = DRAIN;
        DRAIN:   if (drain_empty) state_next = DONE;
        DONE:    if (start) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_rst = (state_reg == IDLE);
    cpu_en  = (state_reg == RUN) && (fifo_count < CW'(DEPTH));
    busy    = (state_reg == RUN) || (state_reg == DRAIN);
    done    = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_count_reg <= '0;
      timed_out_reg  <= 1'b0;
    end else if (start_ok) begin
      step_count_reg <= '0;
      timed_out_reg  <= 1'b0;
    end else begin
      if (cpu_en && step_count_reg != '1) step_count_reg <= step_count_reg + CNT_W'(1);
      if (timeout_step && !abort) timed_out_reg <= 1'b1;
    end
  end

  assign step_count = step_count_reg;
  assign timed_out  = timed_out_reg;

  run_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .push_data  (cpu_data),
    .pop        (fifo_pop),
    .head_valid (out_valid),
    .head_data  (out_data),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized self-checking bench for cpu_run_controller against a queue-based run model.
module tb_cpu_run_controller;
  localparam int DATA_W = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;
  localparam int MAX_STEPS = 10;
`ifdef CPU_RUN_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset, start, abort, cpu_halt, cpu_valid, out_ready;
  logic [DATA_W-1:0] cpu_data;
  logic cpu_rst, cpu_en, out_valid, busy, done, timed_out;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0] step_count;

  int checks = 0;
  int errors = 0;

  int m_mode;
  logic [DATA_W-1:0] m_q[$];
  logic [CNT_W-1:0] m_steps;
  bit m_to;
  logic [DATA_W-1:0] got[$];
  logic [DATA_W-1:0] pushed[$];

  cpu_run_controller #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cpu_halt(cpu_halt), .cpu_valid(cpu_valid),
    .cpu_data(cpu_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .timed_out(timed_out), .step_count(step_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic bit m_en();
    return (m_mode == M_RUN) && (m_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_q.delete();
    m_steps = '0;
    m_to = 1'b0;
  endtask

  task automatic set_in(bit st, bit ab, bit ht, bit vl, logic [DATA_W-1:0] d, bit rd);
    start = st; abort = ab; cpu_halt = ht; cpu_valid = vl; cpu_data = d; out_ready = rd;
  endtask

  // Advance one clock: observe the consumer handshake, then apply the run rules to the model.
  task automatic tick();
    bit en, pop;
    en = m_en();
    pop = (m_mode != M_IDLE) && (m_q.size() > 0) && out_ready;
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      $display("[%0t] pop word %h", $time, out_data);
    end
    @(posedge clk); #1;
    if (en && m_steps != '1) m_steps++;
    if (abort) begin
      m_mode = M_IDLE;
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (en && cpu_valid) m_q.push_back(cpu_data);
      case (m_mode)
        M_IDLE, M_DONE: if (start) begin m_mode = M_RUN; m_steps = '0; m_to = 1'b0; end
        M_RUN: begin
          if (en && cpu_halt) m_mode = M_DRAIN;
          else if (TO_EN && en && m_steps == MAX_STEPS) begin m_mode = M_DRAIN; m_to = 1'b1; end
        end
        M_DRAIN: if (m_q.size() == 0) m_mode = M_DONE;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got %b exp 1", cpu_rst); end checks++;
    if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %b exp 0", cpu_en); end checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL reset_timed_out got %b exp 0", timed_out); end checks++;
    if (step_count !== '0) begin errors++; $display("FAIL reset_step_count got %0d exp 0", step_count); end checks++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_run();
    logic [DATA_W-1:0] exp_words [3];
    int n;
    exp_words[0] = 64'h1; exp_words[1] = 64'h2; exp_words[2] = 64'h3;
    got.delete();
    set_in(1, 0, 0, 0, '0, 1);
    tick();
    start = 1'b0;
    if (cpu_rst !== 1'b0 || cpu_en !== 1'b1) begin errors++; $display("FAIL start_latency rst/en got %b%b exp 01", cpu_rst, cpu_en); end checks++;
    n = 0;
    while (m_mode != M_DONE && n < 30) begin
      int s;
      s = int'(m_steps) + 1;
      set_in(0, 0, (m_mode == M_RUN) && s == 5, (m_mode == M_RUN) && s <= 3, DATA_W'(s), 1);
      if (cpu_en !== m_en()) begin errors++; $display("FAIL basic_cpu_en got %b exp %b", cpu_en, m_en()); end checks++;
      tick();
      n++;
    end
    if (m_mode != M_DONE) begin errors++; $display("FAIL basic_timeout cycles %0d exp done", n); end checks++;
    if (got.size() != 3) begin errors++; $display("FAIL basic_word_count got %0d exp 3", got.size()); end checks++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      if (got[i] !== exp_words[i]) begin errors++; $display("FAIL basic_word%0d got %h exp %h", i, got[i], exp_words[i]); end checks++;
    end
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", done); end checks++;
    if (step_count !== 32'd5) begin errors++; $display("FAIL basic_step_count got %0d exp 5", step_count); end checks++;
  endtask

  task automatic test_backpressure();
    int en_cycles, n;
    got.delete(); pushed.delete();
    set_in(1, 0, 0, 0, '0, 0);
    tick();
    en_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 1, {$urandom, $urandom}, 0);
      if (cpu_en === 1'b1) en_cycles++;
      if (m_en()) pushed.push_back(cpu_data);
      if (cpu_en !== m_en()) begin errors++; $display("FAIL bp_cpu_en cycle %0d got %b exp %b", i, cpu_en, m_en()); end checks++;
      tick();
    end
    if (en_cycles != DEPTH || cpu_en !== 1'b0) begin errors++; $display("FAIL bp_stall en_cycles %0d cpu_en %b exp 4 and 0", en_cycles, cpu_en); end checks++;
    out_ready = 1'b1;
    tick();
    if (cpu_en !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", cpu_en); end checks++;
    n = 0;
    while (m_mode != M_DONE && n < 60) begin
      bit run;
      run = (m_mode == M_RUN);
      set_in(0, 0, run && pushed.size() == 7, run, {$urandom, $urandom}, 1);
      if (m_en() && cpu_valid) pushed.push_back(cpu_data);
      tick();
      n++;
    end
    if (got.size() != pushed.size() || got.size() != 8) begin errors++; $display("FAIL bp_word_count got %0d exp 8", got.size()); end checks++;
    for (int i = 0; i < pushed.size() && i < got.size(); i++) begin
      if (got[i] !== pushed[i]) begin errors++; $display("FAIL bp_word%0d got %h exp %h", i, got[i], pushed[i]); end checks++;
    end
  endtask

  task automatic test_halt_full();
    int lat;
    got.delete(); pushed.delete();
    set_in(1, 0, 0, 0, '0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, i == 3, 1, {$urandom, $urandom}, 0);
      pushed.push_back(cpu_data);
      tick();
    end
    set_in(0, 0, 0, 0, '0, 1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (done !== 1'b1 && lat < 20);
    if (lat != 4) begin errors++; $display("FAIL halt_done_latency got %0d exp 4", lat); end checks++;
    if (got.size() != 4) begin errors++; $display("FAIL halt_word_count got %0d exp 4", got.size()); end checks++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      if (got[i] !== pushed[i]) begin errors++; $display("FAIL halt_word%0d got %h exp %h", i, got[i], pushed[i]); end checks++;
    end
    if (step_count !== 32'd4) begin errors++; $display("FAIL halt_step_count got %0d exp 4", step_count); end checks++;
  endtask

  task automatic test_abort();
    set_in(1, 0, 0, 0, '0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 1, {$urandom, $urandom}, 0);
      tick();
    end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid got %b exp 1", out_valid); end checks++;
    set_in(0, 1, 0, 0, '0, 0);
    tick();
    abort = 1'b0;
    if (cpu_rst !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle rst/valid/busy got %b%b%b exp 100", cpu_rst, out_valid, busy);
    end checks++;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (step_count !== '0 || cpu_en !== 1'b1) begin errors++; $display("FAIL abort_restart step %0d en %b exp 0 1", step_count, cpu_en); end checks++;
    tick();
    if (step_count !== 32'd1) begin errors++; $display("FAIL abort_restart_step got %0d exp 1", step_count); end checks++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_timeout();
    set_in(1, 0, 0, 0, '0, 1);
    tick();
    for (int i = 0; i < 30; i++) begin
      set_in(0, 0, 0, $urandom_range(0, 1), {$urandom, $urandom}, 1);
      if (cpu_en !== m_en()) begin errors++; $display("FAIL to_cpu_en cycle %0d got %b exp %b", i, cpu_en, m_en()); end checks++;
      tick();
    end
`ifdef CPU_RUN_CTRL_TIMEOUT_EN
    if (done !== 1'b1 || timed_out !== 1'b1) begin errors++; $display("FAIL to_done done %b timed_out %b exp 1 1", done, timed_out); end checks++;
    if (step_count !== 32'd10) begin errors++; $display("FAIL to_step_count got %0d exp 10", step_count); end checks++;
    set_in(1, 0, 0, 0, '0, 1);
    tick();
    for (int i = 0; i < 30 && m_mode != M_DONE; i++) begin
      set_in(0, 0, (m_mode == M_RUN) && m_steps == 9, 0, '0, 1);
      tick();
    end
    if (done !== 1'b1 || timed_out !== 1'b0) begin errors++; $display("FAIL to_halt_wins done %b timed_out %b exp 1 0", done, timed_out); end checks++;
    if (step_count !== 32'd10) begin errors++; $display("FAIL to_halt_step got %0d exp 10", step_count); end checks++;
`else
    if (busy !== 1'b1 || timed_out !== 1'b0) begin errors++; $display("FAIL noto_run busy %b timed_out %b exp 1 0", busy, timed_out); end checks++;
    if (step_count !== 32'd30) begin errors++; $display("FAIL noto_step_count got %0d exp 30", step_count); end checks++;
`endif
    set_in(0, 1, 0, 0, '0, 1);
    tick();
    abort = 1'b0;
  endtask

  task automatic test_start_busy_reset();
    set_in(1, 0, 0, 0, '0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(i == 3, 0, 0, 1, {$urandom, $urandom}, 0);
      tick();
    end
    start = 1'b0;
    if (step_count !== 32'd4 || busy !== 1'b1) begin errors++; $display("FAIL start_busy step %0d busy %b exp 4 1", step_count, busy); end checks++;
    if (step_count !== m_steps) begin errors++; $display("FAIL start_busy_model got %0d exp %0d", step_count, m_steps); end checks++;
    reset = 1'b1;
    #1;
    if (cpu_rst !== 1'b1 || cpu_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset rst/en/valid/busy got %b%b%b%b exp 1000", cpu_rst, cpu_en, out_valid, busy);
    end checks++;
    if (out_data !== '0 || step_count !== '0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset_data data %h step %0d done %b exp 0 0 0", out_data, step_count, done);
    end checks++;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      if (cpu_rst !== (m_mode == M_IDLE)) begin errors++; $display("FAIL rnd_cpu_rst cycle %0d got %b", i, cpu_rst); end checks++;
      if (cpu_en !== m_en()) begin errors++; $display("FAIL rnd_cpu_en cycle %0d got %b exp %b", i, cpu_en, m_en()); end checks++;
      if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_out_valid cycle %0d got %b exp %b", i, out_valid, m_q.size() != 0); end checks++;
      if (m_q.size() != 0) begin
        if (out_data !== m_q[0]) begin errors++; $display("FAIL rnd_out_data cycle %0d got %h exp %h", i, out_data, m_q[0]); end checks++;
      end
      if (busy !== (m_mode == M_RUN || m_mode == M_DRAIN)) begin errors++; $display("FAIL rnd_busy cycle %0d got %b", i, busy); end checks++;
      if (done !== (m_mode == M_DONE)) begin errors++; $display("FAIL rnd_done cycle %0d got %b", i, done); end checks++;
      if (step_count !== m_steps) begin errors++; $display("FAIL rnd_step_count cycle %0d got %0d exp %0d", i, step_count, m_steps); end checks++;
      if (timed_out !== m_to) begin errors++; $display("FAIL rnd_timed_out cycle %0d got %b exp %b", i, timed_out, m_to); end checks++;
      tick();
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, '0, 0);
    reset = 1'b1;
    model_reset();
    test_reset();
    test_basic_run();
    test_backpressure();
    test_halt_full();
    test_abort();
    test_timeout();
    test_start_busy_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Sequencing controller placed between the testbench/host and the generated CPU top entity. It holds the CPU in reset until started, steps it with a clock enable, buffers each valid CPU output word in a small FIFO drained over a valid/ready port, and stalls the CPU when the FIFO fills. On CPU halt it drains the FIFO, then reports completion with the executed step count.

## Interface
- DATA_W, 64: CPU output word width
- DEPTH, 4: output FIFO depth in words; power of two, at least 2
- CNT_W, 32: step counter width
- MAX_STEPS, 1000000: step budget, used only with the timeout feature
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE
- abort  in  1  abandon the run from any state
- cpu_rst  out  1  reset driven to the CPU; 1 in IDLE
- cpu_en  out  1  CPU advances one step in each cycle this is 1
- cpu_halt  in  1  CPU halt flag; sampled only when cpu_en=1
- cpu_valid  in  1  CPU output valid; sampled only when cpu_en=1
- cpu_data  in  DATA_W  CPU output word
- out_valid  out  1  FIFO head available
- out_ready  in  1  consumer accepts head when out_valid=1
- out_data  out  DATA_W  FIFO head word
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- timed_out  out  1  last run ended on the step budget
- step_count  out  CNT_W  steps executed in the current/last run

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cpu_rst=1, cpu_en=0. start -> RUN; step_count and timed_out cleared on that edge.
- RUN: cpu_rst=0; cpu_en = (fifo_count < DEPTH), combinational.
- Push: cpu_en=1 and cpu_valid=1 writes cpu_data. A simultaneous push and pop when full cannot occur because cpu_en is 0 when full; push and pop in one cycle leave the count unchanged.
- step_count increments in every cycle with cpu_en=1. It saturates at all-ones.
- cpu_en=1 and cpu_halt=1 -> DRAIN. A word valid in the halt cycle is still pushed.
- DRAIN: cpu_en=0; FIFO empty -> DONE, including when it is already empty on entry (one cycle in DRAIN).
- DONE: done=1, step_count and timed_out held. start -> RUN, with counters cleared.
- abort in RUN, DRAIN or DONE -> IDLE next edge; FIFO flushed, out_valid=0 next cycle. abort takes priority over start, halt and timeout in the same cycle.
- start while busy is ignored.
- Pop: out_valid=1 and out_ready=1 removes the head. The FIFO pops in every state except IDLE.

## Timing
- Reset values: state IDLE, cpu_rst=1, cpu_en=0, out_valid=0, out_data=0, busy=0, done=0, timed_out=0, step_count=0.
- Start latency: start at edge N; cpu_rst=0 and cpu_en=1 during cycle N+1.
- Push-to-output latency: a word pushed at edge N shows out_valid=1 in cycle N+1 when the FIFO was empty. There is no fall-through.
- out_data is stable while out_valid=1 and out_ready=0.
- Stall release: a pop at edge N with FIFO full gives cpu_en=1 in cycle N+1.
- Halt to done: halt at edge N with k words buffered and out_ready held at 1 gives done=1 in cycle N+k+1.

## Configuration
- CPU_RUN_CTRL_TIMEOUT_EN defined: in RUN, when step_count reaches MAX_STEPS with cpu_en=1 at that edge and no halt, the controller goes to DRAIN and sets timed_out=1. If halt occurs on the same edge, halt wins and timed_out stays 0.
- Not defined: there is no budget check, MAX_STEPS is unused and timed_out is tied to 0.

## Structure
- Package cpu_run_ctrl_pkg holds the state enum (IDLE, RUN, DRAIN, DONE) and default width constants.
- Sub-module run_out_fifo: synchronous FIFO with DEPTH entries, DATA_W width, registered head, count output and flush input.
- The controller FSM, step counter and timeout logic stay in the top module.

## Test plan
- Basic run: reset, start, CPU emits 0x1, 0x2, 0x3 over 3 steps, then halts on step 5, out_ready=1. Required: out_data sequence 0x1, 0x2, 0x3; done=1 with step_count=5.
- Backpressure: DEPTH=4, out_ready=0, CPU emits a word every step. Required: cpu_en drops after 4 pushes. Raise out_ready: cpu_en=1 one cycle after the first pop, and no word is lost or duplicated.
- Halt with full FIFO: halt step also has cpu_valid=1 while 3 words are buffered. Required: 4 words drained, then done.
- Abort mid-run with 2 words buffered. Required: IDLE, cpu_rst=1, out_valid=0 next cycle; a new start restarts with step_count from 0.
- Timeout (macro defined, MAX_STEPS=10): CPU never halts. Required: cpu_en stops after 10 steps; done=1, timed_out=1, step_count=10.
- start while busy is ignored; asserting reset mid-run forces all outputs to their reset values immediately.
